alu_share_arbiter: RTL and testbench

//   Shares one ALU (ALU_Control_Unit + ALU) between two requesters: R0, the main datapath, and R1, a secondary unit such as branch-target/CSR logic.

---
 rtl/alu_share_arbiter_if.sv | 55 +++++
 rtl/alu_share_arbiter.sv | 100 ++++++++++
 tb/tb_alu_share_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, shared-ALU and response signals between the arbiter and its environment.
// slave = the arbiter; master = requesters, shared ALU and response consumer.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             R0_Valid;
    logic             R0_Ready;
    logic [1:0]       R0_ALU_Op;
    logic [2:0]       R0_Funct_3;
    logic             R0_Funct_7;
    logic [WIDTH-1:0] R0_A;
    logic [WIDTH-1:0] R0_B;

    logic             R1_Valid;
    logic             R1_Ready;
    logic [1:0]       R1_ALU_Op;
    logic [2:0]       R1_Funct_3;
    logic             R1_Funct_7;
    logic [WIDTH-1:0] R1_A;
    logic [WIDTH-1:0] R1_B;

    logic [1:0]       ALU_Op;
    logic [2:0]       Funct_3;
    logic             Funct_7;
    logic [WIDTH-1:0] ALU_A;
    logic [WIDTH-1:0] ALU_B;
    logic [WIDTH-1:0] ALU_Result;
    logic [3:0]       ALU_Flags;

    // Response handshake: a transfer happens on a rising edge where Rsp_Valid && Rsp_Ready;
    // Rsp_* stay stable while Rsp_Valid && !Rsp_Ready.
    logic             Rsp_Valid;
    logic             Rsp_Ready;
    logic             Rsp_Id;
    logic [WIDTH-1:0] Rsp_Result;
    logic [3:0]       Rsp_Flags;

    modport slave (
        input  R0_Valid, R0_ALU_Op, R0_Funct_3, R0_Funct_7, R0_A, R0_B,
        input  R1_Valid, R1_ALU_Op, R1_Funct_3, R1_Funct_7, R1_A, R1_B,
        input  ALU_Result, ALU_Flags, Rsp_Ready,
        output R0_Ready, R1_Ready,
        output ALU_Op, Funct_3, Funct_7, ALU_A, ALU_B,
        output Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Flags
    );

    modport master (
        output R0_Valid, R0_ALU_Op, R0_Funct_3, R0_Funct_7, R0_A, R0_B,
        output R1_Valid, R1_ALU_Op, R1_Funct_3, R1_Funct_7, R1_A, R1_B,
        output ALU_Result, ALU_Flags, Rsp_Ready,
        input  R0_Ready, R1_Ready,
        input  ALU_Op, Funct_3, Funct_7, ALU_A, ALU_B,
        input  Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Flags
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: R0 has fixed priority, R1 is forced in after
// STARVE_LIMIT consecutive losses. One operation in flight: IDLE -> EXEC -> RESP.
module alu_share_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus,
    output logic [1:0]          dbg_state,
    output logic [3:0]          dbg_starve_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] starve_cnt;
    logic       grant_r0;
    logic       grant_r1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_r0 || grant_r1) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.Rsp_Ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grants are only ever issued in IDLE and are suppressed while reset is asserted.
    always_comb begin
        grant_r0 = 1'b0;
        grant_r1 = 1'b0;
        if (!rst && state_q == IDLE) begin
            grant_r0 = bus.R0_Valid && !(bus.R1_Valid && starve_cnt == LIMIT);
            grant_r1 = bus.R1_Valid && !grant_r0;
        end
        bus.R0_Ready   = grant_r0;
        bus.R1_Ready   = grant_r1;
        dbg_state      = state_q;
        dbg_starve_cnt = starve_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ALU_Op     <= 2'b00;
            bus.Funct_3    <= 3'b000;
            bus.Funct_7    <= 1'b0;
            bus.ALU_A      <= '0;
            bus.ALU_B      <= '0;
            bus.Rsp_Valid  <= 1'b0;
            bus.Rsp_Id     <= 1'b0;
            bus.Rsp_Result <= '0;
            bus.Rsp_Flags  <= 4'b0000;
            starve_cnt     <= 4'd0;
        end else begin
            if (grant_r0) begin
                bus.ALU_Op  <= bus.R0_ALU_Op;
                bus.Funct_3 <= bus.R0_Funct_3;
                bus.Funct_7 <= bus.R0_Funct_7;
                bus.ALU_A   <= bus.R0_A;
                bus.ALU_B   <= bus.R0_B;
                bus.Rsp_Id  <= 1'b0;
            end else if (grant_r1) begin
                bus.ALU_Op  <= bus.R1_ALU_Op;
                bus.Funct_3 <= bus.R1_Funct_3;
                bus.Funct_7 <= bus.R1_Funct_7;
                bus.ALU_A   <= bus.R1_A;
                bus.ALU_B   <= bus.R1_B;
                bus.Rsp_Id  <= 1'b1;
            end

            if (state_q == EXEC) begin
                bus.Rsp_Result <= bus.ALU_Result;
                bus.Rsp_Flags  <= bus.ALU_Flags;
                bus.Rsp_Valid  <= 1'b1;
            end else if (state_q == RESP && bus.Rsp_Ready) begin
                bus.Rsp_Valid  <= 1'b0;
            end

            // Counts consecutive IDLE-cycle losses of a waiting R1.
            if (state_q == IDLE) begin
                if (grant_r1 || !bus.R1_Valid) starve_cnt <= 4'd0;
                else if (starve_cnt != LIMIT)  starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: expected responses are queued at issue time
// and a monitor pops and compares them on every response handshake.
module tb_alu_share_arbiter;
    localparam int W  = 32;
    localparam int EW = 1 + 4 + W;

    logic clk;
    logic rst;
    logic [1:0] dbg_state;
    logic [3:0] dbg_starve_cnt;

    alu_share_arbiter_if #(.WIDTH(W)) bus ();

    alu_share_arbiter #(.WIDTH(W), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    logic [EW-1:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish before 200000");
        $fatal(1, "bench timeout");
    end

    // Shared ALU model: op 01 subtracts, anything else adds. Flags {C, Z, V, S}.
    logic [W:0] alu_sum;
    always_comb begin
        if (bus.ALU_Op == 2'b01) alu_sum = {1'b0, bus.ALU_A} + {1'b0, ~bus.ALU_B} + {{W{1'b0}}, 1'b1};
        else                     alu_sum = {1'b0, bus.ALU_A} + {1'b0, bus.ALU_B};
        bus.ALU_Result = alu_sum[W-1:0];
        bus.ALU_Flags[3] = alu_sum[W];
        bus.ALU_Flags[2] = (alu_sum[W-1:0] == '0);
        if (bus.ALU_Op == 2'b01)
            bus.ALU_Flags[1] = (bus.ALU_A[W-1] != bus.ALU_B[W-1]) && (alu_sum[W-1] != bus.ALU_A[W-1]);
        else
            bus.ALU_Flags[1] = (bus.ALU_A[W-1] == bus.ALU_B[W-1]) && (alu_sum[W-1] != bus.ALU_A[W-1]);
        bus.ALU_Flags[0] = alu_sum[W-1];
    end

    // scoreboard monitor
    always @(negedge clk) begin
        #2;
        if (bus.Rsp_Valid && bus.Rsp_Ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL rsp_unexpected: got id=%0d res=%0d flags=%b, required no response",
                         bus.Rsp_Id, bus.Rsp_Result, bus.Rsp_Flags);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if ({bus.Rsp_Id, bus.Rsp_Flags, bus.Rsp_Result} !== e) begin
                    n_miss++;
                    $display("FAIL rsp: got id=%0d flags=%b res=%0d, required id=%0d flags=%b res=%0d",
                             bus.Rsp_Id, bus.Rsp_Flags, bus.Rsp_Result,
                             e[EW-1], e[W+3:W], e[W-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // driver tasks
    task automatic set_req(input logic id, input logic v, input logic [1:0] op, input logic [2:0] f3,
                           input logic f7, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 1'b0) begin
            bus.R0_Valid = v; bus.R0_ALU_Op = op; bus.R0_Funct_3 = f3;
            bus.R0_Funct_7 = f7; bus.R0_A = a; bus.R0_B = b;
        end else begin
            bus.R1_Valid = v; bus.R1_ALU_Op = op; bus.R1_Funct_3 = f3;
            bus.R1_Funct_7 = f7; bus.R1_A = a; bus.R1_B = b;
        end
    endtask

    task automatic drop_req(input logic id);
        if (id == 1'b0) bus.R0_Valid = 1'b0;
        else            bus.R1_Valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_outputs_zero();
        check("rst_rsp_valid", 64'(bus.Rsp_Valid), 64'd0);
        check("rst_rsp_id", 64'(bus.Rsp_Id), 64'd0);
        check("rst_rsp_result", 64'(bus.Rsp_Result), 64'd0);
        check("rst_rsp_flags", 64'(bus.Rsp_Flags), 64'd0);
        check("rst_alu_op", 64'(bus.ALU_Op), 64'd0);
        check("rst_funct3", 64'(bus.Funct_3), 64'd0);
        check("rst_funct7", 64'(bus.Funct_7), 64'd0);
        check("rst_alu_a", 64'(bus.ALU_A), 64'd0);
        check("rst_alu_b", 64'(bus.ALU_B), 64'd0);
        check("rst_starve", 64'(dbg_starve_cnt), 64'd0);
        check("rst_r0_ready", 64'(bus.R0_Ready), 64'd0);
        check("rst_r1_ready", 64'(bus.R1_Ready), 64'd0);
    endtask

    // One operation from an idle DUT with timing checks at T, T+1, T+2, T+3.
    task automatic run_op(input logic id, input logic [1:0] op, input logic [2:0] f3, input logic f7,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input logic [3:0] flg);
        @(negedge clk);
        bus.Rsp_Ready = 1'b1;
        set_req(id, 1'b1, op, f3, f7, a, b);
        #1;
        check("op_ready_winner", 64'(id ? bus.R1_Ready : bus.R0_Ready), 64'd1);
        check("op_ready_other", 64'(id ? bus.R0_Ready : bus.R1_Ready), 64'd0);
        exp_q.push_back({id, flg, res});
        @(negedge clk);
        drop_req(id);
        #1;
        check("op_alu_a", 64'(bus.ALU_A), 64'(a));
        check("op_alu_b", 64'(bus.ALU_B), 64'(b));
        check("op_alu_op", 64'(bus.ALU_Op), 64'(op));
        check("op_funct3", 64'(bus.Funct_3), 64'(f3));
        check("op_funct7", 64'(bus.Funct_7), 64'(f7));
        check("op_rsp_valid_t1", 64'(bus.Rsp_Valid), 64'd0);
        @(negedge clk);
        #1;
        check("op_rsp_valid_t2", 64'(bus.Rsp_Valid), 64'd1);
        @(negedge clk);
        #1;
        check("op_rsp_valid_t3", 64'(bus.Rsp_Valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.Rsp_Ready = 1'b0;
        set_req(1'b0, 1'b0, 2'b00, 3'b000, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 2'b00, 3'b000, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        bus.R0_Valid = 1'b1;
        #1;
        check_outputs_zero();
        @(negedge clk);
        bus.R0_Valid = 1'b0;
        rst = 1'b0;

        // R0 alone: 5 + 3
        run_op(1'b0, 2'b10, 3'b000, 1'b0, 32'd5, 32'd3, 32'd8, 4'b0000);
        // R1 alone: 7 - 7 sets Zero (and Carry = no borrow)
        run_op(1'b1, 2'b01, 3'b000, 1'b0, 32'd7, 32'd7, 32'd0, 4'b1100);
        // R0 alone: 0x7fffffff + 1 overflows into the sign bit
        run_op(1'b0, 2'b10, 3'b000, 1'b0, 32'h7fff_ffff, 32'd1, 32'h8000_0000, 4'b0011);

        // Both held valid: R1 forced in after four straight losses
        begin
            int acc;
            int cyc;
            logic [4:0] ids [10];
            acc = 0;
            cyc = 0;
            @(negedge clk);
            bus.Rsp_Ready = 1'b1;
            set_req(1'b0, 1'b1, 2'b10, 3'b000, 1'b0, 32'd10, 32'd1);
            set_req(1'b1, 1'b1, 2'b10, 3'b000, 1'b0, 32'd20, 32'd2);
            for (int i = 0; i < 10; i++) begin
                if (i == 4 || i == 9) exp_q.push_back({1'b1, 4'b0000, 32'd22});
                else                  exp_q.push_back({1'b0, 4'b0000, 32'd11});
            end
            while (acc < 10 && cyc < 40) begin
                #1;
                if (bus.R0_Ready || bus.R1_Ready) acc++;
                cyc++;
                @(negedge clk);
            end
            bus.R0_Valid = 1'b0;
            bus.R1_Valid = 1'b0;
            check("starve_accepts", 64'(acc), 64'd10);
            drain();
        end

        // Response back-pressure: outputs held, no readies while stalled
        @(negedge clk);
        bus.Rsp_Ready = 1'b0;
        set_req(1'b0, 1'b1, 2'b10, 3'b000, 1'b0, 32'd100, 32'd23);
        exp_q.push_back({1'b0, 4'b0000, 32'd123});
        #1;
        check("stall_accept", 64'(bus.R0_Ready), 64'd1);
        @(negedge clk);
        drop_req(1'b0);
        @(negedge clk);
        set_req(1'b0, 1'b1, 2'b10, 3'b000, 1'b0, 32'd1, 32'd1);
        set_req(1'b1, 1'b1, 2'b10, 3'b000, 1'b0, 32'd1, 32'd1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_valid", 64'(bus.Rsp_Valid), 64'd1);
            check("stall_id", 64'(bus.Rsp_Id), 64'd0);
            check("stall_result", 64'(bus.Rsp_Result), 64'd123);
            check("stall_flags", 64'(bus.Rsp_Flags), 64'd0);
            check("stall_r0_ready", 64'(bus.R0_Ready), 64'd0);
            check("stall_r1_ready", 64'(bus.R1_Ready), 64'd0);
            @(negedge clk);
        end
        bus.Rsp_Ready = 1'b1;
        bus.R0_Valid = 1'b0;
        bus.R1_Valid = 1'b0;
        #1;
        check("release_valid", 64'(bus.Rsp_Valid), 64'd1);
        @(negedge clk);
        #1;
        check("released_valid", 64'(bus.Rsp_Valid), 64'd0);

        // New R0 request arriving in the handshake cycle waits one cycle
        @(negedge clk);
        bus.Rsp_Ready = 1'b0;
        set_req(1'b1, 1'b1, 2'b01, 3'b000, 1'b0, 32'd3, 32'd1);
        exp_q.push_back({1'b1, 4'b1000, 32'd2});
        #1;
        check("hs_first_accept", 64'(bus.R1_Ready), 64'd1);
        @(negedge clk);
        drop_req(1'b1);
        @(negedge clk);
        @(negedge clk);
        bus.Rsp_Ready = 1'b1;
        set_req(1'b0, 1'b1, 2'b10, 3'b000, 1'b0, 32'd2, 32'd2);
        #1;
        check("hs_r0_ready_blocked", 64'(bus.R0_Ready), 64'd0);
        check("hs_r1_ready_blocked", 64'(bus.R1_Ready), 64'd0);
        exp_q.push_back({1'b0, 4'b0000, 32'd4});
        @(negedge clk);
        #1;
        check("hs_r0_ready_next", 64'(bus.R0_Ready), 64'd1);
        check("hs_state_idle", 64'(dbg_state), 64'd0);
        @(negedge clk);
        drop_req(1'b0);
        drain();

        // Reset during EXEC discards the in-flight R1 operation
        @(negedge clk);
        bus.Rsp_Ready = 1'b1;
        set_req(1'b1, 1'b1, 2'b01, 3'b111, 1'b1, 32'd9, 32'd9);
        #1;
        check("rstx_accept", 64'(bus.R1_Ready), 64'd1);
        @(negedge clk);
        #1;
        check("rstx_in_exec", 64'(dbg_state), 64'd1);
        rst = 1'b1;
        bus.R1_Valid = 1'b0;
        set_req(1'b0, 1'b1, 2'b10, 3'b000, 1'b0, 32'd6, 32'd4);
        @(negedge clk);
        #1;
        check_outputs_zero();
        @(negedge clk);
        #1;
        check("rstx_valid_held", 64'(bus.Rsp_Valid), 64'd0);
        check("rstx_r0_ready_held", 64'(bus.R0_Ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstx_first_accept", 64'(bus.R0_Ready), 64'd1);
        exp_q.push_back({1'b0, 4'b0000, 32'd10});
        @(negedge clk);
        drop_req(1'b0);
        drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
